// File: rtl/cmp_track.sv
// cmp_track: multi-channel threshold comparator with hysteresis and a
// persistence filter. Each channel runs its own debounce FSM. There are two
// register stages (raw compare, then FSM/outputs), so results appear 2 cycles
// after the input beat.

module cmp_track_lane #(
    parameter int WIDTH   = 8,
    parameter int SIGNED  = 1,
    parameter int PERSIST = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             v_in,
    input  logic             v1,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] hyst,
    output logic             hi,
    output logic             rise,
    output logic             fall,
    output logic             eq
);
    // Two guard bits keep y+hyst from wrapping in either signedness.
    localparam int EW    = WIDTH + 2;
    localparam int CNT_W = $clog2(PERSIST + 1);

    typedef enum logic [1:0] {BELOW, RISING, ABOVE, FALLING} state_t;
    typedef struct packed {
        logic up;
        logic dn;
        logic eq;
    } raw_t;

    logic              xs, ys;
    logic signed [EW-1:0] xe, ye, he, yh;
    raw_t              raw, s1;
    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n, cnt_inc;
    logic              rise_n, fall_n;

    assign xs      = (SIGNED != 0) & x[WIDTH-1];
    assign ys      = (SIGNED != 0) & y[WIDTH-1];
    assign xe      = {{2{xs}}, x};
    assign ye      = {{2{ys}}, y};
    assign he      = {2'b00, hyst};
    assign yh      = ye + he;
    assign cnt_inc = cnt + CNT_W'(1);

    // Raw compare against the hysteresis band; the band itself is neutral.
    always_comb begin
        raw    = '0;
        raw.up = xe > yh;
        raw.dn = xe < ye;
        raw.eq = (x == y);
    end

    // Stage 1: capture raw conditions on accepted beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      s1 <= '0;
        else if (clear)  s1 <= '0;
        else if (v_in)   s1 <= raw;
    end

    // Debounce FSM next state; only consumed on stage-1 valid beats.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rise_n  = 1'b0;
        fall_n  = 1'b0;
        case (state)
            BELOW: begin
                cnt_n = '0;
                if (s1.up) begin
                    if (PERSIST == 1) begin
                        state_n = ABOVE;
                        rise_n  = 1'b1;
                    end else begin
                        state_n = RISING;
                        cnt_n   = CNT_W'(1);
                    end
                end
            end
            RISING: begin
                if (!s1.up) begin
                    state_n = BELOW;
                    cnt_n   = '0;
                end else if (cnt_inc == CNT_W'(PERSIST)) begin
                    state_n = ABOVE;
                    rise_n  = 1'b1;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            ABOVE: begin
                cnt_n = '0;
                if (s1.dn) begin
                    if (PERSIST == 1) begin
                        state_n = BELOW;
                        fall_n  = 1'b1;
                    end else begin
                        state_n = FALLING;
                        cnt_n   = CNT_W'(1);
                    end
                end
            end
            FALLING: begin
                if (!s1.dn) begin
                    state_n = ABOVE;
                    cnt_n   = '0;
                end else if (cnt_inc == CNT_W'(PERSIST)) begin
                    state_n = BELOW;
                    fall_n  = 1'b1;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            default: begin
                state_n = BELOW;
                cnt_n   = '0;
            end
        endcase
    end

    // Stage 2: state/count advance on valid beats; pulses last one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BELOW;
            cnt   <= '0;
            hi    <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
            eq    <= 1'b0;
        end else if (clear) begin
            state <= BELOW;
            cnt   <= '0;
            hi    <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
            eq    <= 1'b0;
        end else begin
            rise <= v1 & rise_n;
            fall <= v1 & fall_n;
            if (v1) begin
                state <= state_n;
                cnt   <= cnt_n;
                hi    <= (state_n == ABOVE) || (state_n == FALLING);
                eq    <= s1.eq;
            end
        end
    end
endmodule

module cmp_track #(
    parameter int WIDTH   = 8,
    parameter int CH      = 4,
    parameter int SIGNED  = 1,
    parameter int PERSIST = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                in_valid,
    input  logic [CH*WIDTH-1:0] x,
    input  logic [CH*WIDTH-1:0] y,
    input  logic [WIDTH-1:0]    hyst,
    output logic                out_valid,
    output logic [CH-1:0]       hi,
    output logic [CH-1:0]       rise,
    output logic [CH-1:0]       fall,
    output logic [CH-1:0]       eq
);
    // vld_pipe[0] marks stage-1 data, vld_pipe[STAGES] is the output stage.
    localparam int STAGES = 1;

    logic [STAGES:0] vld_pipe;

    // Valid shift register; clear drops everything in flight and the new beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      vld_pipe <= '0;
        else if (clear)  vld_pipe <= '0;
        else             vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
    end

    assign out_valid = vld_pipe[STAGES];

    for (genvar gi = 0; gi < CH; gi++) begin : g_lane
        cmp_track_lane #(
            .WIDTH  (WIDTH),
            .SIGNED (SIGNED),
            .PERSIST(PERSIST)
        ) u_lane (
            .clk  (clk),
            .rst_n(rst_n),
            .clear(clear),
            .v_in (in_valid),
            .v1   (vld_pipe[0]),
            .x    (x[gi*WIDTH +: WIDTH]),
            .y    (y[gi*WIDTH +: WIDTH]),
            .hyst (hyst),
            .hi   (hi[gi]),
            .rise (rise[gi]),
            .fall (fall[gi]),
            .eq   (eq[gi])
        );
    end
endmodule

// File: doc/cmp_track.md
Name: cmp_track

Overview:
Multi-channel threshold comparator. Compares CH sample pairs x/y on each valid beat, applies a programmable hysteresis band and a persistence filter, and reports a debounced per-channel "above" state plus one-cycle rise/fall event pulses. It is the sequential, parametrised successor of the single-pair combinational comparator, and it sits between sample sources and the event/interrupt logic.

Parameters:
WIDTH, 8, bit width of each x/y sample and of hyst.
CH, 4, number of independent channels.
SIGNED, 1, 1 = x/y are two's complement; 0 = unsigned. hyst is always unsigned.
PERSIST, 3, consecutive qualifying valid beats needed to change state; legal range 1..255.
CNT_W, $clog2(PERSIST+1), persistence counter width. This is a derived parameter and must not be overridden.

Ports:
clk  in  1  clock; all flops are rising-edge.
rst_n  in  1  asynchronous active-low reset.
clear  in  1  synchronous clear of all channel state.
in_valid  in  1  x/y qualify this cycle.
x  in  CH*WIDTH  packed samples; channel i is x[i*WIDTH +: WIDTH].
y  in  CH*WIDTH  packed thresholds, packed the same way as x.
hyst  in  WIDTH  hysteresis margin, shared by all channels, sampled with in_valid.
out_valid  out  1  results below correspond to one input beat.
hi  out  CH  debounced state: 1 = ABOVE or FALLING.
rise  out  CH  one-cycle pulse on entry to ABOVE.
fall  out  CH  one-cycle pulse on entry to BELOW from FALLING.
eq  out  CH  registered raw x==y for the beat.

Behaviour:
- Reset (rst_n=0, asynchronous, at any time including mid-count): out_valid, hi, rise, fall and eq are 0. All FSMs go to BELOW, all counters to 0 and all pipeline valids to 0.
- Pipeline has 2 stages; latency is 2 cycles from in_valid to out_valid. The pipeline has no backpressure and accepts one beat per cycle.
- Stage 1 (registered on in_valid), per channel:
  - Sign-extend x and y (SIGNED=1) or zero-extend them (SIGNED=0) to WIDTH+2 bits. Zero-extend hyst to WIDTH+2 bits.
  - Compute the raw conditions:
    - up = x > y+hyst
    - dn = x < y
    - eq = x == y
  - y+hyst is computed at WIDTH+2 bits and never wraps. For example, with SIGNED=1 and WIDTH=8, y=127 and hyst=255 give a sum of 382, so up is impossible.
  - Band: y <= x <= y+hyst is neutral (up=0, dn=0).
- Stage 2: per-channel FSM. It advances only on stage-1 valid beats. Idle cycles hold state and count, so gaps do not break persistence.
  - BELOW: if up, cnt=1. Go to ABOVE with rise=1 if PERSIST==1, else go to RISING. Otherwise stay in BELOW with cnt=0.
  - RISING: if up, cnt++. When cnt reaches PERSIST, go to ABOVE, pulse rise and set cnt=0. If not up, return to BELOW with cnt=0 and no pulse.
  - ABOVE: if dn, cnt=1. Go to BELOW with fall=1 if PERSIST==1, else go to FALLING. Otherwise stay in ABOVE.
  - FALLING: if dn, cnt++. When cnt reaches PERSIST, go to BELOW, pulse fall and set cnt=0. If not dn, return to ABOVE with cnt=0.
- Output timing:
  - hi, rise and fall reflect the post-transition state and are registered with out_valid.
  - rise and fall are 0 whenever out_valid=0.
  - hi holds its value between valid beats.
  - rise and fall are mutually exclusive per channel.
- Channels are fully independent; events on one channel never affect another.
- clear=1:
  - Next cycle, every FSM is in BELOW, cnt=0, hi=0, rise/fall/eq=0.
  - Both pipeline valids are 0, so in-flight beats are discarded.
  - If in_valid arrives in the same cycle as clear, clear wins and the beat is dropped (no out_valid for it).
  - clear has no effect while rst_n=0.
- A hyst change takes effect on the next in_valid beat. The FSM is not reset.

Test Plan:
1. WIDTH=8, CH=4, PERSIST=3, SIGNED=1, hyst=4. Drive ch0 x=10, y=5 for 3 consecutive valid beats -> rise[0]=1 and hi[0]=1 on the 3rd out_valid (2 cycles after the 3rd in_valid). Repeat from reset with 2 beats then x=7 -> no rise, hi[0] stays 0.
2. Hysteresis: with ch0 in ABOVE and y=5, drive x=7 (in band) for 10 beats -> hi[0]=1 with no fall. Then drive x=4 for 3 beats -> fall[0] pulse on the 3rd out_valid and hi[0]=0.
3. Signedness: x=0x05, y=0xF0, hyst=4, 3 beats. SIGNED=1 -> rise (5 > -12). SIGNED=0 -> no rise (5 < 240, dn). Overflow case: SIGNED=1, y=0x7F, hyst=0xFF, x=0x7F -> up never asserts; eq=1.
4. Gaps and independence: ch1 qualifying beats separated by 5 idle cycles each -> rise[1] on the 3rd valid beat. Ch2/ch3 are held at x<y and stay BELOW with no pulses.
5. Mid-count disruption: ch0 in RISING with cnt=2. (a) Assert rst_n=0 asynchronously between edges -> all outputs 0 immediately, and after release 3 new beats are needed. (b) Assert clear together with in_valid -> that beat yields no out_valid, FSM in BELOW, no rise.
6. PERSIST=1: a single x=10, y=5, hyst=4 beat -> rise in that beat's out_valid. The next beat with x=2 -> fall; the two pulses are in separate cycles.
